jtag_tap_controller: RTL and testbench

- IEEE 1149.1 TAP state machine that sequences the JTAG instruction register and the data registers.
- Decodes TMS on rising TCK edges into the 16 TAP states.
- Drives the IR control signals (ClockIR, ShiftIR, UpdateIR, TapReset) and the matching DR signals.
- Registers the selected scan chain onto TDO on falling TCK edges.
- Sits between the chip JTAG pins and the instruction register / data register instances.

---
 rtl/jtag_tap_controller.sv | 135 +++++++++++++
 tb/tb_jtag_tap_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: TMS-driven state machine on rising TCK, scan-path
// control strobes and TDO retimed on falling TCK so they settle while TCK is low.
//
// state     | meaning
// ----------+------------------------------------------
// TLR    (F)| test-logic reset, TapReset asserted
// RTI    (C)| run-test / idle
// SEL_DR (7)| select DR scan
// CAP_DR (6)| capture into selected data register
// SHIFT_DR(2)| shift data register, TDO driven
// EXIT1_DR(1)| exit1 DR
// PAUSE_DR(3)| pause DR, no clocks or shift enables
// EXIT2_DR(0)| exit2 DR
// UPD_DR (5)| update data register
// SEL_IR (4)| select IR scan
// CAP_IR (E)| capture into instruction register
// SHIFT_IR(A)| shift instruction register, TDO driven
// EXIT1_IR(9)| exit1 IR
// PAUSE_IR(B)| pause IR, no clocks or shift enables
// EXIT2_IR(8)| exit2 IR
// UPD_IR (D)| update instruction register
module jtag_tap_controller #(
    parameter logic TDO_IDLE = 1'b1
) (
    input  logic       TCK,
    input  logic       Reset,
    input  logic       TMS,
    input  logic       IR_TDO,
    input  logic       DR_TDO,
    output logic [3:0] State,
    output logic       TapReset,
    output logic       Select,
    output logic       ClockIR,
    output logic       ShiftIR,
    output logic       UpdateIR,
    output logic       ClockDR,
    output logic       ShiftDR,
    output logic       UpdateDR,
    output logic       Enable,
    output logic       TDO
);

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SHIFT_DR = 4'h2,
        EXIT1_DR = 4'h1,
        PAUSE_DR = 4'h3,
        EXIT2_DR = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SHIFT_IR = 4'hA,
        EXIT1_IR = 4'h9,
        PAUSE_IR = 4'hB,
        EXIT2_IR = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_t;

    tap_state_t r_state;
    logic       r_gate_ir;
    logic       r_gate_dr;

    logic w_select_nxt;
    logic w_enable_nxt;
    logic w_gate_ir_nxt;
    logic w_gate_dr_nxt;

    always_ff @(posedge TCK or posedge Reset) begin
        if (Reset) begin
            r_state <= TLR;
        end else begin
            case (r_state)
                TLR:      r_state <= TMS ? TLR      : RTI;
                RTI:      r_state <= TMS ? SEL_DR   : RTI;
                SEL_DR:   r_state <= TMS ? SEL_IR   : CAP_DR;
                CAP_DR:   r_state <= TMS ? EXIT1_DR : SHIFT_DR;
                SHIFT_DR: r_state <= TMS ? EXIT1_DR : SHIFT_DR;
                EXIT1_DR: r_state <= TMS ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: r_state <= TMS ? EXIT2_DR : PAUSE_DR;
                EXIT2_DR: r_state <= TMS ? UPD_DR   : SHIFT_DR;
                UPD_DR:   r_state <= TMS ? SEL_DR   : RTI;
                SEL_IR:   r_state <= TMS ? TLR      : CAP_IR;
                CAP_IR:   r_state <= TMS ? EXIT1_IR : SHIFT_IR;
                SHIFT_IR: r_state <= TMS ? EXIT1_IR : SHIFT_IR;
                EXIT1_IR: r_state <= TMS ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: r_state <= TMS ? EXIT2_IR : PAUSE_IR;
                EXIT2_IR: r_state <= TMS ? UPD_IR   : SHIFT_IR;
                UPD_IR:   r_state <= TMS ? SEL_DR   : RTI;
                default:  r_state <= TLR;
            endcase
        end
    end

    assign State = r_state;

    assign w_select_nxt  = r_state inside {SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR,
                                           PAUSE_IR, EXIT2_IR, UPD_IR};
    assign w_enable_nxt  = (r_state == SHIFT_IR) || (r_state == SHIFT_DR);
    assign w_gate_ir_nxt = (r_state == CAP_IR) || (r_state == SHIFT_IR);
    assign w_gate_dr_nxt = (r_state == CAP_DR) || (r_state == SHIFT_DR);

    // Gates only move while TCK is low, so the ANDed clocks cannot glitch.
    always_ff @(negedge TCK or posedge Reset) begin
        if (Reset) begin
            TapReset  <= 1'b1;
            Select    <= 1'b0;
            ShiftIR   <= 1'b0;
            ShiftDR   <= 1'b0;
            UpdateIR  <= 1'b0;
            UpdateDR  <= 1'b0;
            Enable    <= 1'b0;
            r_gate_ir <= 1'b0;
            r_gate_dr <= 1'b0;
            TDO       <= TDO_IDLE;
        end else begin
            TapReset  <= (r_state == TLR);
            Select    <= w_select_nxt;
            ShiftIR   <= (r_state == SHIFT_IR);
            ShiftDR   <= (r_state == SHIFT_DR);
            UpdateIR  <= (r_state == UPD_IR);
            UpdateDR  <= (r_state == UPD_DR);
            Enable    <= w_enable_nxt;
            r_gate_ir <= w_gate_ir_nxt;
            r_gate_dr <= w_gate_dr_nxt;
            TDO       <= w_enable_nxt ? (w_select_nxt ? IR_TDO : DR_TDO) : TDO_IDLE;
        end
    end

    assign ClockIR = TCK & r_gate_ir;
    assign ClockDR = TCK & r_gate_dr;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed-vector bench for jtag_tap_controller: TAP walk table, TDO mux
// sequence and asynchronous mid-scan reset.
module tb_jtag_tap_controller;

    logic       TCK;
    logic       Reset;
    logic       TMS;
    logic       IR_TDO;
    logic       DR_TDO;
    logic [3:0] State;
    logic       TapReset, Select, ClockIR, ShiftIR, UpdateIR;
    logic       ClockDR, ShiftDR, UpdateDR, Enable, TDO;

    int errors = 0;
    int checks = 0;
    int n_cir = 0;
    int n_cdr = 0;
    int n_upd_ir = 0;
    int n_upd_dr = 0;

    jtag_tap_controller #(.TDO_IDLE(1'b1)) dut (
        .TCK(TCK), .Reset(Reset), .TMS(TMS), .IR_TDO(IR_TDO), .DR_TDO(DR_TDO),
        .State(State), .TapReset(TapReset), .Select(Select), .ClockIR(ClockIR),
        .ShiftIR(ShiftIR), .UpdateIR(UpdateIR), .ClockDR(ClockDR),
        .ShiftDR(ShiftDR), .UpdateDR(UpdateDR), .Enable(Enable), .TDO(TDO)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    always @(posedge ClockIR)  n_cir++;
    always @(posedge ClockDR)  n_cdr++;
    always @(posedge UpdateIR) n_upd_ir++;
    always @(posedge UpdateDR) n_upd_dr++;

    // outs = {TapReset, Select, Enable, ShiftIR, ShiftDR, UpdateIR, UpdateDR}
    typedef struct packed {
        logic       tms;
        logic [3:0] st;
        logic [6:0] outs;
        logic       cir;
        logic       cdr;
    } vec_t;

    vec_t vecs [41];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [6:0] outs_now();
        return {TapReset, Select, Enable, ShiftIR, ShiftDR, UpdateIR, UpdateDR};
    endfunction

    // Called just after a falling edge; ends just after the next falling edge.
    task automatic step(input logic tms, output logic [3:0] st, output logic [6:0] outs,
                        output int cir, output int cdr);
        int a, b;
        a = n_cir;
        b = n_cdr;
        TMS = tms;
        @(posedge TCK);
        #1 st = State;
        @(negedge TCK);
        #1 outs = outs_now();
        cir = n_cir - a;
        cdr = n_cdr - b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] st;
        logic [6:0] outs;
        int cir, cdr;

        vecs[0]  = '{1'b0, 4'hC, 7'b0000000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'h7, 7'b0000000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'h4, 7'b0100000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'hE, 7'b0100000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'hA, 7'b0111000, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'hA, 7'b0111000, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 4'h9, 7'b0100000, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 4'hD, 7'b0100010, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'hC, 7'b0000000, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'h7, 7'b0000000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'h6, 7'b0000000, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'h2, 7'b0010100, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 4'h1, 7'b0000000, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 4'h3, 7'b0000000, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'h3, 7'b0000000, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 4'h3, 7'b0000000, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 4'h0, 7'b0000000, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 4'h5, 7'b0000001, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 4'hC, 7'b0000000, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 4'h7, 7'b0000000, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 4'h6, 7'b0000000, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 4'h2, 7'b0010100, 1'b0, 1'b1};
        vecs[22] = '{1'b1, 4'h1, 7'b0000000, 1'b0, 1'b1};
        vecs[23] = '{1'b1, 4'h5, 7'b0000001, 1'b0, 1'b0};
        vecs[24] = '{1'b1, 4'h7, 7'b0000000, 1'b0, 1'b0};
        vecs[25] = '{1'b1, 4'h4, 7'b0100000, 1'b0, 1'b0};
        vecs[26] = '{1'b1, 4'hF, 7'b1000000, 1'b0, 1'b0};
        vecs[27] = '{1'b0, 4'hC, 7'b0000000, 1'b0, 1'b0};
        vecs[28] = '{1'b1, 4'h7, 7'b0000000, 1'b0, 1'b0};
        vecs[29] = '{1'b1, 4'h4, 7'b0100000, 1'b0, 1'b0};
        vecs[30] = '{1'b0, 4'hE, 7'b0100000, 1'b0, 1'b0};
        vecs[31] = '{1'b1, 4'h9, 7'b0100000, 1'b1, 1'b0};
        vecs[32] = '{1'b0, 4'hB, 7'b0100000, 1'b0, 1'b0};
        vecs[33] = '{1'b1, 4'h8, 7'b0100000, 1'b0, 1'b0};
        vecs[34] = '{1'b0, 4'hA, 7'b0111000, 1'b0, 1'b0};
        vecs[35] = '{1'b1, 4'h9, 7'b0100000, 1'b1, 1'b0};
        vecs[36] = '{1'b1, 4'hD, 7'b0100010, 1'b0, 1'b0};
        vecs[37] = '{1'b1, 4'h7, 7'b0000000, 1'b0, 1'b0};
        vecs[38] = '{1'b1, 4'h4, 7'b0100000, 1'b0, 1'b0};
        vecs[39] = '{1'b1, 4'hF, 7'b1000000, 1'b0, 1'b0};
        vecs[40] = '{1'b1, 4'hF, 7'b1000000, 1'b0, 1'b0};

        Reset  = 1'b1;
        TMS    = 1'b1;
        IR_TDO = 1'b1;
        DR_TDO = 1'b0;
        @(negedge TCK);
        @(negedge TCK);
        #1;
        chk("rst_state", 0, State, 4'hF);
        chk("rst_outs", 0, outs_now(), 7'b1000000);
        chk("rst_tdo", 0, TDO, 1'b1);
        chk("rst_clocks", 0, {ClockIR, ClockDR}, 2'b00);
        Reset = 1'b0;

        for (int i = 0; i < 41; i++) begin
            step(vecs[i].tms, st, outs, cir, cdr);
            chk("state", i, st, vecs[i].st);
            chk("outs", i, outs, vecs[i].outs);
            chk("clock_ir", i, cir, vecs[i].cir);
            chk("clock_dr", i, cdr, vecs[i].cdr);
        end

        // TDO mux: IR pattern 1,0,1, idle value outside shift, DR path.
        step(1'b0, st, outs, cir, cdr);
        step(1'b1, st, outs, cir, cdr);
        step(1'b1, st, outs, cir, cdr);
        step(1'b0, st, outs, cir, cdr);
        chk("seq_cap_ir", 0, st, 4'hE);
        IR_TDO = 1'b1;
        step(1'b0, st, outs, cir, cdr);
        chk("tdo_ir", 0, TDO, 1'b1);
        IR_TDO = 1'b0;
        step(1'b0, st, outs, cir, cdr);
        chk("tdo_ir", 1, TDO, 1'b0);
        IR_TDO = 1'b1;
        step(1'b0, st, outs, cir, cdr);
        chk("tdo_ir", 2, TDO, 1'b1);
        IR_TDO = 1'b0;
        step(1'b1, st, outs, cir, cdr);
        chk("tdo_exit1_idle", 0, TDO, 1'b1);
        step(1'b1, st, outs, cir, cdr);
        step(1'b1, st, outs, cir, cdr);
        step(1'b0, st, outs, cir, cdr);
        IR_TDO = 1'b1;
        DR_TDO = 1'b0;
        step(1'b0, st, outs, cir, cdr);
        chk("seq_shift_dr", 0, st, 4'h2);
        chk("tdo_dr", 0, TDO, 1'b0);
        chk("shiftdr_on", 0, ShiftDR, 1'b1);
        DR_TDO = 1'b1;
        IR_TDO = 1'b0;
        step(1'b0, st, outs, cir, cdr);
        chk("tdo_dr", 1, TDO, 1'b1);

        // Asynchronous reset while TCK is high in ShiftDR.
        @(posedge TCK);
        #2;
        chk("mid_pre_state", 0, State, 4'h2);
        Reset = 1'b1;
        #1;
        chk("mid_state", 0, State, 4'hF);
        chk("mid_outs", 0, outs_now(), 7'b1000000);
        chk("mid_tdo", 0, TDO, 1'b1);
        chk("mid_clock_dr", 0, ClockDR, 1'b0);
        repeat (3) @(negedge TCK);
        #1;
        chk("mid_hold_state", 0, State, 4'hF);
        Reset = 1'b0;
        step(1'b0, st, outs, cir, cdr);
        chk("post_rst_state", 0, st, 4'hC);
        chk("post_rst_outs", 0, outs, 7'b0000000);
        chk("tdo_idle_rti", 0, TDO, 1'b1);

        chk("upd_ir_pulses", 0, n_upd_ir, 3);
        chk("upd_dr_pulses", 0, n_upd_dr, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
